// File: rtl/omok_move_ctrl.sv
// omok_move_ctrl: cursor/turn sequencer for an N x N omok board; issues stone writes and scans the
// placed stone's four lines for WIN_LEN-in-a-row. Draw detection is built with `define OMOK_DRAW_DETECT_EN.
module omok_move_ctrl #(
  parameter int N       = 10,
  parameter int POS_W   = 7,
  parameter int WIN_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_code,
  input  logic             new_game,
  input  logic [N*N-1:0]   board_state,
  input  logic [N*N-1:0]   turn_map,
  output logic             cmd_ready,
  output logic [POS_W-1:0] cursor_pos,
  output logic             cur_turn,
  output logic             wr_en,
  output logic [POS_W-1:0] wr_pos,
  output logic             wr_color,
  output logic             clr_board,
  output logic             put_reject,
  output logic             busy,
  output logic             game_over,
  output logic             winner,
  output logic             draw
);

  localparam int RC_W  = $clog2(N) + 2;
  localparam int ST_W  = $clog2(WIN_LEN) + 1;
  localparam int CNT_W = $clog2(2 * WIN_LEN) + 1;

  localparam logic [RC_W-1:0]  CTR_RC    = RC_W'(N / 2 - 1);
  localparam logic [RC_W-1:0]  MAX_RC    = RC_W'(N - 1);
  localparam logic [POS_W-1:0] CTR_POS   = POS_W'((N / 2 - 1) * N + N / 2 - 1);
  localparam logic [POS_W-1:0] ROW_STEP  = POS_W'(N);
  localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(WIN_LEN - 2);
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_LEN);
  localparam logic [1:0]       DIR_LAST  = 2'd3;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_PUT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SCAN   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t           state_r;
  logic [RC_W-1:0]  row_r;
  logic [RC_W-1:0]  col_r;
  logic [POS_W-1:0] cursor_pos_r;
  logic             cur_turn_r;
  logic             wr_en_r;
  logic [POS_W-1:0] wr_pos_r;
  logic             wr_color_r;
  logic             clr_board_r;
  logic             put_reject_r;
  logic             game_over_r;
  logic             winner_r;
  logic [1:0]       dir_r;
  logic             side_r;
  logic [ST_W-1:0]  step_r;
  logic [CNT_W-1:0] count_r;

`ifdef OMOK_DRAW_DETECT_EN
  localparam int SC_W = $clog2(N * N + 1);
  localparam logic [SC_W-1:0] FULL_CNT = SC_W'(N * N);
  logic [SC_W-1:0] stones_r;
  logic            draw_r;
`endif

  logic                   row_mv_s;
  logic                   col_inc_s;
  logic                   col_dec_s;
  logic signed [RC_W-1:0] off_s;
  logic signed [RC_W-1:0] row_d_s;
  logic signed [RC_W-1:0] col_d_s;
  logic signed [RC_W-1:0] pr_s;
  logic signed [RC_W-1:0] pc_s;
  logic                   on_board_s;
  logic [POS_W-1:0]       probe_idx_s;
  logic                   hit_s;
  logic                   side_done_s;
  logic [CNT_W-1:0]       total_s;

  // Direction decode: H(0,+1), V(+1,0), D(+1,+1), A(+1,-1).
  always_comb begin
    row_mv_s  = 1'b0;
    col_inc_s = 1'b0;
    col_dec_s = 1'b0;
    case (dir_r)
      2'd0: col_inc_s = 1'b1;
      2'd1: row_mv_s = 1'b1;
      2'd2: begin
        row_mv_s  = 1'b1;
        col_inc_s = 1'b1;
      end
      2'd3: begin
        row_mv_s  = 1'b1;
        col_dec_s = 1'b1;
      end
      default: begin
        row_mv_s  = 1'b0;
        col_inc_s = 1'b0;
        col_dec_s = 1'b0;
      end
    endcase
  end

  // Probe cell for the current direction/side/step; off-board probes never index the board.
  always_comb begin
    off_s = RC_W'(step_r) + RC_W'(1);
    if (row_mv_s) begin
      row_d_s = off_s;
    end else begin
      row_d_s = '0;
    end
    if (col_inc_s) begin
      col_d_s = off_s;
    end else if (col_dec_s) begin
      col_d_s = -off_s;
    end else begin
      col_d_s = '0;
    end
    if (side_r) begin
      pr_s = $signed(row_r) - row_d_s;
      pc_s = $signed(col_r) - col_d_s;
    end else begin
      pr_s = $signed(row_r) + row_d_s;
      pc_s = $signed(col_r) + col_d_s;
    end
    on_board_s = !pr_s[RC_W-1] && !pc_s[RC_W-1] &&
                 (pr_s <= $signed(MAX_RC)) && (pc_s <= $signed(MAX_RC));
    if (on_board_s) begin
      probe_idx_s = POS_W'(pr_s) * ROW_STEP + POS_W'(pc_s);
    end else begin
      probe_idx_s = '0;
    end
    hit_s       = on_board_s && board_state[probe_idx_s] && (turn_map[probe_idx_s] == cur_turn_r);
    side_done_s = !hit_s || (step_r == STEP_LAST);
    if (hit_s) begin
      total_s = count_r + CNT_W'(1);
    end else begin
      total_s = count_r;
    end
  end

  // Game sequencer: cursor, turn, write strobes, line scan and game-over lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      row_r        <= CTR_RC;
      col_r        <= CTR_RC;
      cursor_pos_r <= CTR_POS;
      cur_turn_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_pos_r     <= '0;
      wr_color_r   <= 1'b0;
      clr_board_r  <= 1'b0;
      put_reject_r <= 1'b0;
      game_over_r  <= 1'b0;
      winner_r     <= 1'b0;
      dir_r        <= 2'd0;
      side_r       <= 1'b0;
      step_r       <= '0;
      count_r      <= '0;
`ifdef OMOK_DRAW_DETECT_EN
      stones_r     <= '0;
      draw_r       <= 1'b0;
`endif
    end else begin
      wr_en_r      <= 1'b0;
      clr_board_r  <= 1'b0;
      put_reject_r <= 1'b0;
      if (new_game) begin
        state_r      <= ST_IDLE;
        row_r        <= CTR_RC;
        col_r        <= CTR_RC;
        cursor_pos_r <= CTR_POS;
        cur_turn_r   <= 1'b0;
        clr_board_r  <= 1'b1;
        game_over_r  <= 1'b0;
        winner_r     <= 1'b0;
        dir_r        <= 2'd0;
        side_r       <= 1'b0;
        step_r       <= '0;
`ifdef OMOK_DRAW_DETECT_EN
        stones_r     <= '0;
        draw_r       <= 1'b0;
`endif
      end else begin
`ifdef OMOK_DRAW_DETECT_EN
        if (wr_en_r) begin
          stones_r <= stones_r + SC_W'(1);
        end
`endif
        case (state_r)
          ST_IDLE, ST_OVER: begin
            if (cmd_valid) begin
              case (cmd_code)
                CMD_UP: if (row_r != '0) begin
                  row_r        <= row_r - RC_W'(1);
                  cursor_pos_r <= cursor_pos_r - ROW_STEP;
                end
                CMD_DOWN: if (row_r != MAX_RC) begin
                  row_r        <= row_r + RC_W'(1);
                  cursor_pos_r <= cursor_pos_r + ROW_STEP;
                end
                CMD_LEFT: if (col_r != '0) begin
                  col_r        <= col_r - RC_W'(1);
                  cursor_pos_r <= cursor_pos_r - POS_W'(1);
                end
                CMD_RIGHT: if (col_r != MAX_RC) begin
                  col_r        <= col_r + RC_W'(1);
                  cursor_pos_r <= cursor_pos_r + POS_W'(1);
                end
                CMD_PUT: begin
                  if ((state_r == ST_OVER) || board_state[cursor_pos_r]) begin
                    put_reject_r <= 1'b1;
                  end else begin
                    state_r    <= ST_WRITE;
                    wr_en_r    <= 1'b1;
                    wr_pos_r   <= cursor_pos_r;
                    wr_color_r <= cur_turn_r;
                  end
                end
                default: state_r <= state_r;
              endcase
            end
          end
          ST_WRITE: state_r <= ST_SETTLE;
          ST_SETTLE: begin
            state_r <= ST_SCAN;
            dir_r   <= 2'd0;
            side_r  <= 1'b0;
            step_r  <= '0;
            count_r <= CNT_W'(1);
          end
          ST_SCAN: begin
            if (!side_done_s) begin
              step_r  <= step_r + ST_W'(1);
              count_r <= total_s;
            end else if (!side_r) begin
              side_r  <= 1'b1;
              step_r  <= '0;
              count_r <= total_s;
            end else if (total_s >= WIN_CNT) begin
              state_r     <= ST_OVER;
              game_over_r <= 1'b1;
              winner_r    <= cur_turn_r;
            end else if (dir_r != DIR_LAST) begin
              dir_r   <= dir_r + 2'd1;
              side_r  <= 1'b0;
              step_r  <= '0;
              count_r <= CNT_W'(1);
            end else begin
`ifdef OMOK_DRAW_DETECT_EN
              if (stones_r == FULL_CNT) begin
                state_r     <= ST_OVER;
                game_over_r <= 1'b1;
                draw_r      <= 1'b1;
              end else begin
                state_r    <= ST_IDLE;
                cur_turn_r <= !cur_turn_r;
              end
`else
              state_r    <= ST_IDLE;
              cur_turn_r <= !cur_turn_r;
`endif
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = (state_r == ST_IDLE) || (state_r == ST_OVER);
  assign busy       = !((state_r == ST_IDLE) || (state_r == ST_OVER));
  assign cursor_pos = cursor_pos_r;
  assign cur_turn   = cur_turn_r;
  assign wr_en      = wr_en_r;
  assign wr_pos     = wr_pos_r;
  assign wr_color   = wr_color_r;
  assign clr_board  = clr_board_r;
  assign put_reject = put_reject_r;
  assign game_over  = game_over_r;
  assign winner     = winner_r;
`ifdef OMOK_DRAW_DETECT_EN
  assign draw       = draw_r;
`else
  assign draw       = 1'b0;
`endif

endmodule
